// File: rtl/div_result_bcd_pkg.sv
// Shared definitions for the divider result BCD converter.
//   W          operand width of quotient/remainder (matches the divider)
//   ND         BCD digits per result, ceil(W*log10(2)), derived from W
//   CW         width of the bit counter, wide enough to hold W
//   bcd_state_t  converter FSM states
//   bcd_t        packed BCD word, digit 0 in [3:0]
package div_result_bcd_pkg;

    localparam int W  = 8;
    // ceil(W*log10(2)) in integer arithmetic: log10(2) ~= 30103/100000
    localparam int ND = (W * 30103 + 99999) / 100000;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } bcd_state_t;

    typedef logic [4*ND-1:0] bcd_t;

    // Double-dabble digit correction: a digit of 5 or more gets 3 added so
    // that the following left shift carries correctly into the next digit.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= 4'd5) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// Bus between the divider/consumer side and the BCD converter.
//   ready_in, quotient_in, remainder_in : divider result and ready flag
//   q_bcd, r_bcd, bcd_valid, bcd_ack    : converted result with valid/ack handshake
//   busy, overrun                       : converter status
// master: the divider/consumer side; slave: the converter.
interface div_result_bcd_if;
    import div_result_bcd_pkg::*;

    logic           ready_in;
    logic [W-1:0]   quotient_in;
    logic [W-1:0]   remainder_in;
    bcd_t           q_bcd;
    bcd_t           r_bcd;
    logic           bcd_valid;
    logic           bcd_ack;
    logic           busy;
    logic           overrun;

    modport master (
        output ready_in, quotient_in, remainder_in, bcd_ack,
        input  q_bcd, r_bcd, bcd_valid, busy, overrun
    );

    modport slave (
        input  ready_in, quotient_in, remainder_in, bcd_ack,
        output q_bcd, r_bcd, bcd_valid, busy, overrun
    );

endinterface

// File: rtl/div_result_bcd_dabble_step.sv
// One combinational double-dabble step.
//   acc       current BCD accumulator
//   shift_in  next binary bit (MSB first) shifted into the accumulator
//   acc_next  accumulator after add-3 correction and one left shift
module div_result_bcd_dabble_step
    import div_result_bcd_pkg::*;
(
    input  bcd_t acc,
    input  logic shift_in,
    output bcd_t acc_next
);

    bcd_t adj_s;

    // Correct every digit, then shift the whole word left by one bit.
    always_comb begin
        adj_s = acc;
        for (int d = 0; d < ND; d++) begin
            adj_s[4*d +: 4] = dabble_adjust(acc[4*d +: 4]);
        end
        acc_next = {adj_s[4*ND-2:0], shift_in};
    end

endmodule

// File: rtl/div_result_bcd.sv
// Downstream stage of the 8-bit restoring divider: on each rising edge of the
// divider's ready, captures quotient and remainder, converts both to packed
// BCD one bit per clock, and holds the result behind a valid/ack handshake.
//   clk   rising-edge clock shared with the divider
//   rst   asynchronous, active-high reset
//   bus   slave side of div_result_bcd_if (ready/operands in, BCD/status out)
module div_result_bcd
    import div_result_bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    div_result_bcd_if.slave   bus
);

    bcd_state_t     state_r, state_nxt;
    logic           ready_d_r;
    logic [CW-1:0]  cnt_r;
    logic [W-1:0]   sq_r, sr_r;
    bcd_t           q_acc_r, r_acc_r;
    bcd_t           q_step_s, r_step_s;
    bcd_t           q_bcd_r, r_bcd_r;
    logic           bcd_valid_r;
    logic           overrun_r;
    logic           busy_s;
    logic           new_res_s;
    logic           load_s;

    assign new_res_s = bus.ready_in & ~ready_d_r;

    // A new result is taken in IDLE, or in HOLD when it coincides with the ack.
    assign load_s = new_res_s &
                    ((state_r == IDLE) | ((state_r == HOLD) & bus.bcd_ack));

    div_result_bcd_dabble_step u_q_step (
        .acc      (q_acc_r),
        .shift_in (sq_r[W-1]),
        .acc_next (q_step_s)
    );

    div_result_bcd_dabble_step u_r_step (
        .acc      (r_acc_r),
        .shift_in (sr_r[W-1]),
        .acc_next (r_step_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (new_res_s) state_nxt = CONVERT;
                else           state_nxt = IDLE;
            end
            CONVERT: begin
                // cnt reaching zero means all W bits are shifted in; this
                // extra cycle transfers the accumulators to the outputs.
                if (cnt_r == CW'(0)) state_nxt = HOLD;
                else                 state_nxt = CONVERT;
            end
            HOLD: begin
                if (bus.bcd_ack) begin
                    if (new_res_s) state_nxt = CONVERT;
                    else           state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy_s = 1'b0;
        if (state_r == CONVERT) busy_s = 1'b1;
        else                    busy_s = 1'b0;
    end

    // Edge detect, shift registers, accumulators, output registers and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // ready_d starts high so a divider already idle after reset is
            // not mistaken for a fresh result.
            ready_d_r   <= 1'b1;
            cnt_r       <= CW'(0);
            sq_r        <= '0;
            sr_r        <= '0;
            q_acc_r     <= '0;
            r_acc_r     <= '0;
            q_bcd_r     <= '0;
            r_bcd_r     <= '0;
            bcd_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            ready_d_r <= bus.ready_in;
            if (load_s) begin
                sq_r        <= bus.quotient_in;
                sr_r        <= bus.remainder_in;
                q_acc_r     <= '0;
                r_acc_r     <= '0;
                cnt_r       <= CW'(W);
                bcd_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    CONVERT: begin
                        if (cnt_r == CW'(0)) begin
                            q_bcd_r     <= q_acc_r;
                            r_bcd_r     <= r_acc_r;
                            bcd_valid_r <= 1'b1;
                        end else begin
                            q_acc_r <= q_step_s;
                            r_acc_r <= r_step_s;
                            sq_r    <= {sq_r[W-2:0], 1'b0};
                            sr_r    <= {sr_r[W-2:0], 1'b0};
                            cnt_r   <= cnt_r - CW'(1);
                        end
                    end
                    HOLD: begin
                        if (bus.bcd_ack) bcd_valid_r <= 1'b0;
                        else             bcd_valid_r <= bcd_valid_r;
                    end
                    default: begin
                        bcd_valid_r <= bcd_valid_r;
                    end
                endcase
            end
            // Results arriving while busy or still held are dropped.
            if (new_res_s && !load_s && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.q_bcd     = q_bcd_r;
    assign bus.r_bcd     = r_bcd_r;
    assign bus.bcd_valid = bcd_valid_r;
    assign bus.busy      = busy_s;
    assign bus.overrun   = overrun_r;

endmodule
